// File: rtl/sdram_port_master.sv
// Burst requester in front of the SDRAM controller: accepts one command at a time,
// stages write data in a FWFT FIFO and returns read data registered by one cycle.
module sdram_port_master #(
  parameter int unsigned WBUF_DEPTH = 256,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic        wq_valid,
  input  logic [15:0] wq_data,
  output logic        wq_ready,
  output logic [8:0]  wq_count,
  output logic        rd_valid,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        err,
  output logic [23:0] sdram_wr_addr,
  output logic [15:0] sdram_wr_data,
  output logic        sdram_wr_req,
  output logic [8:0]  sdwr_bytes,
  input  logic        sdram_wr_ack,
  output logic [23:0] sdram_rd_addr,
  output logic        sdram_rd_req,
  output logic [8:0]  sdrd_bytes,
  input  logic [15:0] sdram_rd_data,
  input  logic        sdram_rd_ack,
  input  logic        sdram_init_done,
  input  logic        sdram_busy
);

  localparam int unsigned PTR_W   = $clog2(WBUF_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned LEN_W   = 9;
  localparam int unsigned TO_W    = 13;
  localparam int unsigned MAX_LEN = 256;

  typedef enum logic [2:0] {
    S_WAIT_INIT,
    S_IDLE,
    S_WR_REQ,
    S_WR_DATA,
    S_RD_REQ,
    S_RD_DATA
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             wr_req_q, rd_req_q, done_q, err_q, rd_valid_q;
  logic [15:0]      rd_data_q;
  logic [23:0]      wr_addr_q, rd_addr_q;
  logic [LEN_W-1:0] wr_bytes_q, rd_bytes_q;

  logic [15:0]      mem_q [WBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             accept, done_d, err_d, rd_strobe;
  logic             push, pop, flush;
  logic             bad_len, wr_side, ack;
  logic [LEN_W-1:0] remaining, count9;

  assign cmd_ready     = (state_q == S_IDLE) && !sdram_busy;
  assign wq_ready      = (state_q != S_WAIT_INIT) && (count_q < CNT_W'(WBUF_DEPTH));
  assign wq_count      = LEN_W'(count_q);
  assign sdram_wr_data = (count_q != '0) ? mem_q[rd_ptr_q] : 16'h0000;

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign done          = done_q;
  assign err           = err_q;
  assign sdram_wr_req  = wr_req_q;
  assign sdram_rd_req  = rd_req_q;
  assign sdram_wr_addr = wr_addr_q;
  assign sdram_rd_addr = rd_addr_q;
  assign sdwr_bytes    = wr_bytes_q;
  assign sdrd_bytes    = rd_bytes_q;

  assign push      = wq_valid && wq_ready;
  assign count9    = LEN_W'(count_q);
  assign remaining = len_q - ack_cnt_q;
  assign bad_len   = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN)) ||
                     (cmd_we && (cmd_len > count9));
  assign wr_side   = (state_q == S_WR_REQ) || (state_q == S_WR_DATA);
  assign ack       = wr_side ? sdram_wr_ack : sdram_rd_ack;

  // Transfer sequencing: request, ack counting, timeout and init-loss abort.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    to_cnt_d  = to_cnt_q;
    accept    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    pop       = 1'b0;
    rd_strobe = 1'b0;
    flush     = 1'b0;
    case (state_q)
      S_WAIT_INIT: begin
        if (sdram_init_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!sdram_init_done) begin
          state_d = S_WAIT_INIT;
        end else if (cmd_valid && cmd_ready) begin
          if (bad_len) begin
            err_d = 1'b1;
          end else begin
            accept    = 1'b1;
            ack_cnt_d = '0;
            to_cnt_d  = '0;
            state_d   = cmd_we ? S_WR_REQ : S_RD_REQ;
          end
        end
      end
      S_WR_REQ, S_WR_DATA, S_RD_REQ, S_RD_DATA: begin
        if (!sdram_init_done) begin
          state_d = S_WAIT_INIT;
          err_d   = 1'b1;
          flush   = wr_side;
        end else if (ack && (ack_cnt_q < len_q)) begin
          ack_cnt_d = ack_cnt_q + LEN_W'(1);
          to_cnt_d  = '0;
          pop       = wr_side;
          rd_strobe = !wr_side;
          if ((ack_cnt_q + LEN_W'(1)) == len_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = wr_side ? S_WR_DATA : S_RD_DATA;
          end
        end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          flush   = wr_side;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      default: state_d = S_WAIT_INIT;
    endcase
  end

  // A failed write discards the words it would have consumed so the FIFO stays aligned.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = count_q - CNT_W'(remaining);
      rd_ptr_d = rd_ptr_q + PTR_W'(remaining);
    end else if (pop) begin
      count_d  = count_q - CNT_W'(1);
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push) count_d = count_d + CNT_W'(1);
  end

  always_ff @(posedge clk_100m) begin
    if (push) mem_q[wr_ptr_q] <= wq_data;
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      state_q    <= S_WAIT_INIT;
      len_q      <= '0;
      ack_cnt_q  <= '0;
      to_cnt_q   <= '0;
      wr_req_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wr_bytes_q <= '0;
      rd_bytes_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ack_cnt_q  <= ack_cnt_d;
      to_cnt_q   <= to_cnt_d;
      wr_req_q   <= (state_d == S_WR_REQ);
      rd_req_q   <= (state_d == S_RD_REQ);
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_strobe;
      if (rd_strobe) rd_data_q <= sdram_rd_data;
      if (accept) begin
        len_q <= cmd_len;
        if (cmd_we) begin
          wr_addr_q  <= cmd_addr;
          wr_bytes_q <= cmd_len;
        end else begin
          rd_addr_q  <= cmd_addr;
          rd_bytes_q <= cmd_len;
        end
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_sdram_port_master.sv
// Directed bench for sdram_port_master: command table plus hand-built timeout,
// flush and mid-burst reset sequences against a queue model of the write FIFO.
module tb_sdram_port_master;

  localparam int unsigned WBUF_DEPTH = 256;
  localparam int unsigned TIMEOUT    = 4096;

  logic        clk_100m = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic        wq_valid, wq_ready;
  logic [15:0] wq_data;
  logic [8:0]  wq_count;
  logic        rd_valid, done, err;
  logic [15:0] rd_data;
  logic [23:0] sdram_wr_addr, sdram_rd_addr;
  logic [15:0] sdram_wr_data, sdram_rd_data;
  logic        sdram_wr_req, sdram_wr_ack, sdram_rd_req, sdram_rd_ack;
  logic [8:0]  sdwr_bytes, sdrd_bytes;
  logic        sdram_init_done, sdram_busy;

  always #5 clk_100m = ~clk_100m;

  sdram_port_master #(.WBUF_DEPTH(WBUF_DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_100m(clk_100m), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wq_valid(wq_valid), .wq_data(wq_data), .wq_ready(wq_ready), .wq_count(wq_count),
    .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
    .sdram_wr_addr(sdram_wr_addr), .sdram_wr_data(sdram_wr_data),
    .sdram_wr_req(sdram_wr_req), .sdwr_bytes(sdwr_bytes), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_addr(sdram_rd_addr), .sdram_rd_req(sdram_rd_req), .sdrd_bytes(sdrd_bytes),
    .sdram_rd_data(sdram_rd_data), .sdram_rd_ack(sdram_rd_ack),
    .sdram_init_done(sdram_init_done), .sdram_busy(sdram_busy)
  );

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic [8:0]  len;
    int          pre;
    logic [15:0] base;
    logic [15:0] step;
    logic        exp_err;
  } vec_t;

  vec_t        tbl [13];
  int          checks = 0;
  int          failures = 0;
  int          wr_rises = 0;
  int          rd_rises = 0;
  int          rv_cnt = 0;
  logic        wr_prev = 1'b0;
  logic        rd_prev = 1'b0;
  logic [15:0] model [$];
  logic        ok;

  always @(posedge clk_100m) begin
    wr_prev <= sdram_wr_req;
    rd_prev <= sdram_rd_req;
    if (sdram_wr_req && !wr_prev) wr_rises <= wr_rises + 1;
    if (sdram_rd_req && !rd_prev) rd_rises <= rd_rises + 1;
    if (rd_valid) rv_cnt <= rv_cnt + 1;
  end

  task automatic tick();
    @(posedge clk_100m);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic outs_any();
    return |{cmd_ready, wq_ready, wq_count, rd_valid, rd_data, done, err,
             sdram_wr_addr, sdram_wr_data, sdram_wr_req, sdwr_bytes,
             sdram_rd_addr, sdram_rd_req, sdrd_bytes};
  endfunction

  task automatic push_words(input int n, input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      int w;
      w = 0;
      while (!wq_ready && w < 20) begin tick(); w++; end
      if (!wq_ready) begin
        chk("wq_ready_wait", 32'(wq_ready), 32'd1);
        return;
      end
      d = base + 16'(i) * step;
      wq_valid = 1'b1;
      wq_data  = d;
      tick();
      wq_valid = 1'b0;
      model.push_back(d);
    end
  endtask

  task automatic issue(input logic we, input logic [23:0] addr, input logic [8:0] len,
                       output logic accepted);
    int w;
    w = 0;
    while (!cmd_ready && w < 50) begin tick(); w++; end
    if (!cmd_ready) begin
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      accepted = 1'b0;
      return;
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    tick();
    cmd_valid = 1'b0;
    accepted  = 1'b1;
  endtask

  task automatic run_write(input logic [23:0] addr, input logic [8:0] len);
    int wb, cb;
    logic [15:0] e;
    logic acc;
    wb = wr_rises;
    issue(1'b1, addr, len, acc);
    if (!acc) return;
    chk("wr_err", 32'(err), 32'd0);
    chk("wr_req", 32'(sdram_wr_req), 32'd1);
    chk("wr_bytes", 32'(sdwr_bytes), 32'(len));
    chk("wr_addr", 32'(sdram_wr_addr), 32'(addr));
    for (int i = 0; i < int'(len); i++) begin
      if (i % 3 == 2) tick();
      e = model.pop_front();
      chk("wr_data", 32'(sdram_wr_data), 32'(e));
      sdram_wr_ack = 1'b1;
      tick();
      sdram_wr_ack = 1'b0;
      if (i == 0) chk("wr_req_drop", 32'(sdram_wr_req), 32'd0);
    end
    chk("wr_done", 32'(done), 32'd1);
    cb = model.size();
    sdram_wr_ack = 1'b1;
    tick();
    sdram_wr_ack = 1'b0;
    chk("wr_done_pulse", 32'(done), 32'd0);
    tick();
    chk("wr_count", 32'(wq_count), 32'(cb));
    chk("wr_req_once", 32'(wr_rises - wb), 32'd1);
  endtask

  task automatic run_read(input logic [23:0] addr, input logic [8:0] len,
                          input logic [15:0] base, input logic [15:0] step);
    int rb, vb;
    logic [15:0] e;
    logic acc;
    rb = rd_rises;
    vb = rv_cnt;
    issue(1'b0, addr, len, acc);
    if (!acc) return;
    chk("rd_err", 32'(err), 32'd0);
    chk("rd_req", 32'(sdram_rd_req), 32'd1);
    chk("rd_bytes", 32'(sdrd_bytes), 32'(len));
    chk("rd_addr", 32'(sdram_rd_addr), 32'(addr));
    for (int i = 0; i < int'(len); i++) begin
      if (i % 4 == 3) tick();
      e = base + 16'(i) * step;
      sdram_rd_ack  = 1'b1;
      sdram_rd_data = e;
      tick();
      sdram_rd_ack  = 1'b0;
      sdram_rd_data = 16'hdead;
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_data", 32'(rd_data), 32'(e));
      if (i == 0) chk("rd_req_drop", 32'(sdram_rd_req), 32'd0);
    end
    chk("rd_done", 32'(done), 32'd1);
    sdram_rd_ack = 1'b1;
    tick();
    sdram_rd_ack = 1'b0;
    chk("rd_done_pulse", 32'(done), 32'd0);
    tick();
    chk("rd_strobes", 32'(rv_cnt - vb), 32'(len));
    chk("rd_req_once", 32'(rd_rises - rb), 32'd1);
  endtask

  task automatic run_reject(input logic we, input logic [23:0] addr, input logic [8:0] len);
    int wb, rb, cb;
    logic acc;
    wb = wr_rises;
    rb = rd_rises;
    cb = model.size();
    issue(we, addr, len, acc);
    if (!acc) return;
    chk("rej_err", 32'(err), 32'd1);
    tick();
    chk("rej_err_pulse", 32'(err), 32'd0);
    tick();
    tick();
    chk("rej_noreq", 32'((wr_rises - wb) + (rd_rises - rb)), 32'd0);
    chk("rej_count", 32'(wq_count), 32'(cb));
    chk("rej_idle", 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_len = '0;
    wq_valid = 1'b0; wq_data = '0;
    sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0; sdram_rd_data = '0;
    sdram_init_done = 1'b0; sdram_busy = 1'b0;

    tbl[0]  = '{1'b1, 24'h000010, 9'd4,   4,   16'h1111, 16'h1111, 1'b0};
    tbl[1]  = '{1'b0, 24'h000010, 9'd3,   0,   16'h000a, 16'h0001, 1'b0};
    tbl[2]  = '{1'b1, 24'h000020, 9'd5,   2,   16'h5000, 16'h0001, 1'b1};
    tbl[3]  = '{1'b0, 24'h000020, 9'd0,   0,   16'h0000, 16'h0000, 1'b1};
    tbl[4]  = '{1'b0, 24'h000020, 9'd300, 0,   16'h0000, 16'h0000, 1'b1};
    tbl[5]  = '{1'b1, 24'h000030, 9'd2,   0,   16'h0000, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 24'h123456, 9'd1,   3,   16'h6000, 16'h0010, 1'b0};
    tbl[7]  = '{1'b0, 24'hc00001, 9'd1,   0,   16'hbeef, 16'h0001, 1'b0};
    tbl[8]  = '{1'b1, 24'h000040, 9'd3,   1,   16'h7000, 16'h0001, 1'b0};
    tbl[9]  = '{1'b1, 24'h400000, 9'd256, 256, 16'h0000, 16'h0003, 1'b0};
    tbl[10] = '{1'b0, 24'h3fffff, 9'd256, 0,   16'h8000, 16'h0001, 1'b0};
    tbl[11] = '{1'b0, 24'h000050, 9'd257, 0,   16'h0000, 16'h0000, 1'b1};
    tbl[12] = '{1'b1, 24'h000060, 9'd256, 0,   16'h0000, 16'h0000, 1'b1};

    // Reset and initialisation wait
    tick(); tick(); tick();
    chk("reset_outs", 32'(outs_any()), 32'd0);
    rst = 1'b0;
    begin
      logic any;
      any = 1'b0;
      for (int c = 0; c < 200; c++) begin
        tick();
        any = any | outs_any();
      end
      chk("wait_init_outs", 32'(any), 32'd0);
    end
    sdram_init_done = 1'b1;
    chk("init_ready_pre", 32'(cmd_ready), 32'd0);
    tick();
    chk("init_ready", 32'(cmd_ready), 32'd1);
    chk("init_wq_ready", 32'(wq_ready), 32'd1);
    sdram_busy = 1'b1;
    #1;
    chk("busy_ready", 32'(cmd_ready), 32'd0);
    sdram_busy = 1'b0;
    #1;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].pre > 0) push_words(tbl[i].pre, tbl[i].base, tbl[i].step);
      chk("pre_count", 32'(wq_count), 32'(model.size()));
      if (model.size() == int'(WBUF_DEPTH)) chk("full_ready", 32'(wq_ready), 32'd0);
      if (tbl[i].exp_err) run_reject(tbl[i].we, tbl[i].addr, tbl[i].len);
      else if (tbl[i].we) run_write(tbl[i].addr, tbl[i].len);
      else run_read(tbl[i].addr, tbl[i].len, tbl[i].base, tbl[i].step);
    end

    // Read with no ack until timeout, then a normal read
    begin
      int hi;
      logic seen;
      hi = 0;
      seen = 1'b0;
      issue(1'b0, 24'h000005, 9'd2, ok);
      for (int c = 0; c < int'(TIMEOUT) + 100; c++) begin
        if (err) begin seen = 1'b1; break; end
        if (sdram_rd_req) hi++;
        tick();
      end
      chk("to_err", 32'(seen), 32'd1);
      chk("to_req_drop", 32'(sdram_rd_req), 32'd0);
      chk("to_idle", 32'(cmd_ready), 32'd1);
      chk("to_req_len", 32'(hi >= int'(TIMEOUT) - 1 && hi <= int'(TIMEOUT) + 1), 32'd1);
      run_read(24'h000006, 9'd1, 16'h0123, 16'h0001);
    end

    // Write timeout after one ack (with a simultaneous push) flushes the rest
    begin
      logic seen;
      logic [15:0] e;
      seen = 1'b0;
      push_words(3, 16'h9000, 16'h0001);
      issue(1'b1, 24'h000070, 9'd3, ok);
      e = model.pop_front();
      chk("to_wr_data", 32'(sdram_wr_data), 32'(e));
      sdram_wr_ack = 1'b1;
      wq_valid = 1'b1;
      wq_data = 16'h9100;
      tick();
      sdram_wr_ack = 1'b0;
      wq_valid = 1'b0;
      model.push_back(16'h9100);
      chk("ackpush_count", 32'(wq_count), 32'd3);
      for (int c = 0; c < int'(TIMEOUT) + 100; c++) begin
        if (err) begin seen = 1'b1; break; end
        tick();
      end
      void'(model.pop_front());
      void'(model.pop_front());
      chk("to_wr_err", 32'(seen), 32'd1);
      chk("flush_count", 32'(wq_count), 32'(model.size()));
      chk("flush_head", 32'(sdram_wr_data), 32'(model[0]));
      chk("to_wr_req_drop", 32'(sdram_wr_req), 32'd0);
      chk("to_wr_idle", 32'(cmd_ready), 32'd1);
      run_write(24'h000080, 9'd1);
    end

    // Reset in the middle of a four-word write
    begin
      logic [15:0] e;
      push_words(4, 16'ha000, 16'h0001);
      issue(1'b1, 24'h000090, 9'd4, ok);
      for (int i = 0; i < 2; i++) begin
        e = model.pop_front();
        chk("mid_wr_data", 32'(sdram_wr_data), 32'(e));
        sdram_wr_ack = 1'b1;
        tick();
        sdram_wr_ack = 1'b0;
      end
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_outs", 32'(outs_any()), 32'd0);
      chk("mid_rst_count", 32'(wq_count), 32'd0);
      model.delete();
      #1;
      rst = 1'b0;
      #1;
      chk("mid_rst_wait_init", 32'(cmd_ready), 32'd0);
      chk("mid_rst_wq_ready", 32'(wq_ready), 32'd0);
      tick();
      chk("mid_rst_reinit", 32'(cmd_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
